uxrom_ext: RTL and testbench
============================

# uxrom_ext

Parametrised discrete-logic PRG-switching mapper covering the UxROM family: UNROM/UOROM (switchable bank at $8000, fixed last bank at $C000), the inverted-fixed variant (fixed first bank at $8000, switchable at $C000), and the UNROM-512 extension (CHR-RAM banking, one-screen mirroring control). It sits between the cartridge CPU/PPU pins and the PRG/CHR memory controllers in the mapper slot. It replaces the M2-clocked bank latch with a latch in the system clock domain, and it adds optional bus-conflict emulation.

## Interface
- PRG_BANK_BITS, 5, width of the 16 KiB PRG bank number. Range 1..8; max 5 if CHR_BANK_BITS>0 or ONE_SCREEN_CTRL=1.
- CHR_BANK_BITS, 0, width of the 8 KiB CHR bank number. Range 0..2.
- FIXED_LOW, 0, fixed-window placement. 0: $C000 is fixed to the all-ones bank. 1: $8000 is fixed to bank 0.
- BUS_CONFLICT, 1, when 1 the written value is ANDed with the ROM byte at the write address.
- ONE_SCREEN_CTRL, 0, when 1 register bit 7 drives ciram_a10.
- ADDR_BITS, 22, width of prg_addr and chr_addr.

Ports:
- clk, in, 1, system clock. Runs at 40 MHz or more.
- reset, in, 1, synchronous, active-high.
- m2, in, 1, CPU M2 pin. Asynchronous to clk.
- cpu_addr, in, 16, CPU address.
- cpu_rw, in, 1, 1 = read.
- cpu_data_in, in, 8, CPU data bus.
- prg_data, in, 8, PRG ROM data at the current prg_addr.
- ppu_addr, in, 14, PPU address.
- ppu_rd, in, 1, active-low.
- ppu_wr, in, 1, active-low.
- chr_ram, in, 1, CHR is RAM.
- mirroring, in, 1, header mirroring. 1 = vertical.
- prg_addr, out, ADDR_BITS, PRG memory address.
- prg_oe, out, 1, PRG output enable.
- chr_addr, out, ADDR_BITS, CHR memory address.
- chr_ce, out, 1, CHR chip enable.
- chr_oe, out, 1, CHR output enable.
- chr_we, out, 1, CHR write enable.
- ciram_ce, out, 1, CIRAM chip enable.
- ciram_a10, out, 1, CIRAM A10.
- bank_write, out, 1, one-clk pulse on each register commit.

## Operation
- Register `bank_reg[7:0]` layout:
  - prg_bank = bits [PRG_BANK_BITS-1:0].
  - chr_bank = bits [5+CHR_BANK_BITS-1:5].
  - one-screen select = bit 7.
  - Unused bits are stored but ignored.
- CPU decode:
  - prg_oe = cpu_addr[15] & cpu_rw.
  - FIXED_LOW=0: the window is cpu_addr[14] ? all-ones : prg_bank.
  - FIXED_LOW=1: the window is cpu_addr[14] ? prg_bank : 0.
  - prg_addr = zero-extend({window, cpu_addr[13:0]}).
- PPU decode:
  - ciram_ce = chr_ce = !ppu_addr[13].
  - chr_oe = !ppu_rd.
  - chr_we = chr_ram & !ppu_wr & !ppu_addr[13].
  - chr_addr = zero-extend({chr_bank, ppu_addr[12:0]}). chr_bank is absent when CHR_BANK_BITS=0.
- ciram_a10:
  - ONE_SCREEN_CTRL=1: bit 7 of bank_reg.
  - Otherwise: mirroring ? ppu_addr[10] : ppu_addr[11].
- M2 handling:
  - Two-flop synchronizer m2_s1→m2_s2, plus history flop m2_d.
  - A fall is detected when m2_d=1 and m2_s2=0.
- Snapshot:
  - On every clk with m2_s1=1, register cpu_addr, cpu_rw, cpu_data_in and prg_data.
  - Set `armed`.
- Commit:
  - Condition: fall detected & armed & snap_addr[15] & !snap_rw.
  - Value written: BUS_CONFLICT ? snap_data & snap_prg : snap_data.
  - bank_write pulses for that cycle.
  - `armed` clears on every detected fall.
- Read-modify-write instructions produce two consecutive writes. Each commits; the last value wins.

## Timing
- Reset values: bank_reg=0, m2_s1=m2_s2=m2_d=0, armed=0, snapshot=0, bank_write=0.
  - After reset, prg_addr for $8000 is bank 0 (FIXED_LOW=0).
  - ciram_a10 follows mirroring, or is 0 when ONE_SCREEN_CTRL=1.
- Decode outputs are combinational from pins and bank_reg. No clk latency.
- Write latency: bank_reg changes 3 clk edges after the M2 pin falls (2 sync + 1 commit). bank_write is high during that cycle.
- Reset has priority over commit in the same cycle.
- Reset asserted mid-M2-high clears armed. The following fall is ignored unless m2_s1=1 is observed after reset deasserts.
- No fall is detected from reset state, because m2_d=0.
- Glitch-free: bank_reg changes at most once per M2 cycle. The window always reflects the old value or the new value, never a mix.

## Test plan
- Reset, then read $8000 and $C000 (defaults) → prg_addr = 0x0000 and 0x7C000.
- Write 0x03 to $8000 with prg_data=0xFF → bank_write 3 clks after M2 falls; reading $8123 gives prg_addr 0x0C123.
- BUS_CONFLICT=1: write 0x07 while prg_data=0x05 → prg_bank=5. With BUS_CONFLICT=0 → prg_bank=7.
- FIXED_LOW=1: write 0x02 → $8000 maps to 0x00000, $C010 maps to 0x08010.
- CHR_BANK_BITS=2, ONE_SCREEN_CTRL=1: write 0xE1 → chr_addr for PPU $0100 = 0x06100, ciram_a10=1, PPU write to $0100 with chr_ram=1 asserts chr_we.
- Assert reset during an M2-high write cycle → no commit at that fall, bank_reg=0, bank_write stays 0.

Source files
------------

// File: rtl/uxrom_ext.sv
`timescale 1ns/1ps
// uxrom_ext -- UxROM-family PRG switching mapper (UNROM/UOROM, inverted-fixed
// variant, UNROM-512 CHR banking and one-screen control).
//
// A single 8-bit bank register is written by CPU stores to $8000-$FFFF. The
// M2 pin is brought into the clk domain with a two-flop synchronizer. The bus
// is snapshotted while M2 is high, and the register commits on the falling M2
// edge. All address decode is combinational from the pins and the register.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   m2                CPU M2 pin (asynchronous to clk)
//   cpu_addr/rw/data  CPU bus; prg_data is the ROM byte at the current prg_addr
//   ppu_addr/rd/wr    PPU bus (rd/wr active-low)
//   chr_ram           CHR is RAM (gates chr_we)
//   mirroring         header mirroring, 1 = vertical
//   prg_addr, prg_oe  PRG memory address / output enable
//   chr_addr, chr_ce, chr_oe, chr_we   CHR memory controls
//   ciram_ce, ciram_a10                nametable RAM controls
//   bank_write        one-clk pulse when the bank register is committed
module uxrom_ext #(
    parameter int PRG_BANK_BITS   = 5,
    parameter int CHR_BANK_BITS   = 0,
    parameter bit FIXED_LOW       = 1'b0,
    parameter bit BUS_CONFLICT    = 1'b1,
    parameter bit ONE_SCREEN_CTRL = 1'b0,
    parameter int ADDR_BITS       = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m2,
    input  logic [15:0]          cpu_addr,
    input  logic                 cpu_rw,
    input  logic [7:0]           cpu_data_in,
    input  logic [7:0]           prg_data,
    input  logic [13:0]          ppu_addr,
    input  logic                 ppu_rd,
    input  logic                 ppu_wr,
    input  logic                 chr_ram,
    input  logic                 mirroring,
    output logic [ADDR_BITS-1:0] prg_addr,
    output logic                 prg_oe,
    output logic [ADDR_BITS-1:0] chr_addr,
    output logic                 chr_ce,
    output logic                 chr_oe,
    output logic                 chr_we,
    output logic                 ciram_ce,
    output logic                 ciram_a10,
    output logic                 bank_write
);

    logic        m2_s1_q, m2_s1_d;
    logic        m2_s2_q, m2_s2_d;
    logic        m2_d_q, m2_d_d;
    logic        armed_q, armed_d;
    logic [15:0] snap_addr_q, snap_addr_d;
    logic        snap_rw_q, snap_rw_d;
    logic [7:0]  snap_data_q, snap_data_d;
    logic [7:0]  snap_prg_q, snap_prg_d;
    logic [7:0]  bank_reg_q, bank_reg_d;
    logic        bank_write_q, bank_write_d;

    logic        m2_fall;
    logic        commit;
    logic [7:0]  wr_value;

    // Bank latch control: synchronize M2, snapshot the bus while M2 is high,
    // commit on the synchronized falling edge.
    always_comb begin
        m2_s1_d     = m2;
        m2_s2_d     = m2_s1_q;
        m2_d_d      = m2_s2_q;
        m2_fall     = m2_d_q & ~m2_s2_q;

        snap_addr_d = snap_addr_q;
        snap_rw_d   = snap_rw_q;
        snap_data_d = snap_data_q;
        snap_prg_d  = snap_prg_q;

        armed_d     = armed_q;
        if (m2_fall) begin
            armed_d = 1'b0;
        end
        // A new high phase already visible re-arms even if a fall is seen now.
        if (m2_s1_q) begin
            snap_addr_d = cpu_addr;
            snap_rw_d   = cpu_rw;
            snap_data_d = cpu_data_in;
            snap_prg_d  = prg_data;
            armed_d     = 1'b1;
        end

        commit       = m2_fall & armed_q & snap_addr_q[15] & ~snap_rw_q;
        wr_value     = BUS_CONFLICT ? (snap_data_q & snap_prg_q) : snap_data_q;
        bank_reg_d   = commit ? wr_value : bank_reg_q;
        bank_write_d = commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m2_s1_q      <= 1'b0;
            m2_s2_q      <= 1'b0;
            m2_d_q       <= 1'b0;
            armed_q      <= 1'b0;
            snap_addr_q  <= '0;
            snap_rw_q    <= 1'b0;
            snap_data_q  <= '0;
            snap_prg_q   <= '0;
            bank_reg_q   <= '0;
            bank_write_q <= 1'b0;
        end else begin
            m2_s1_q      <= m2_s1_d;
            m2_s2_q      <= m2_s2_d;
            m2_d_q       <= m2_d_d;
            armed_q      <= armed_d;
            snap_addr_q  <= snap_addr_d;
            snap_rw_q    <= snap_rw_d;
            snap_data_q  <= snap_data_d;
            snap_prg_q   <= snap_prg_d;
            bank_reg_q   <= bank_reg_d;
            bank_write_q <= bank_write_d;
        end
    end

    assign bank_write = bank_write_q;

    // CPU side decode.
    logic [PRG_BANK_BITS-1:0] prg_bank;
    logic [PRG_BANK_BITS-1:0] window;
    logic [PRG_BANK_BITS+13:0] prg_full;

    always_comb begin
        prg_bank = bank_reg_q[PRG_BANK_BITS-1:0];
        if (FIXED_LOW) begin
            window = cpu_addr[14] ? prg_bank : '0;
        end else begin
            window = cpu_addr[14] ? '1 : prg_bank;
        end
        prg_full = {window, cpu_addr[13:0]};
    end

    assign prg_addr = ADDR_BITS'(prg_full);
    assign prg_oe   = cpu_addr[15] & cpu_rw;

    // PPU side decode; the CHR bank field only exists on UNROM-512 style builds.
    logic [CHR_BANK_BITS+12:0] chr_full;

    generate
        if (CHR_BANK_BITS > 0) begin : g_chr_bank
            assign chr_full = {bank_reg_q[5 +: CHR_BANK_BITS], ppu_addr[12:0]};
        end else begin : g_no_chr_bank
            assign chr_full = ppu_addr[12:0];
        end
    endgenerate

    assign chr_addr  = ADDR_BITS'(chr_full);
    assign chr_ce    = ~ppu_addr[13];
    assign ciram_ce  = ~ppu_addr[13];
    assign chr_oe    = ~ppu_rd;
    assign chr_we    = chr_ram & ~ppu_wr & ~ppu_addr[13];
    assign ciram_a10 = ONE_SCREEN_CTRL ? bank_reg_q[7]
                                       : (mirroring ? ppu_addr[10] : ppu_addr[11]);

    // Register bits and snapshot fields that a given parameter set ignores.
    logic unused_bits;
    assign unused_bits = ^{bank_reg_q, snap_prg_q};

endmodule

// File: tb/tb_uxrom_ext.sv
`timescale 1ns/1ps
module tb_uxrom_ext;

    logic        clk;
    logic        reset;
    logic        m2;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_in;
    logic [7:0]  prg_data;
    logic [13:0] ppu_addr;
    logic        ppu_rd;
    logic        ppu_wr;
    logic        chr_ram;
    logic        mirroring;

    logic [21:0] prg_addr_a, prg_addr_b, prg_addr_c;
    logic [21:0] chr_addr_a, chr_addr_b, chr_addr_c;
    logic        prg_oe_a, prg_oe_b, prg_oe_c;
    logic        chr_ce_a, chr_ce_b, chr_ce_c;
    logic        chr_oe_a, chr_oe_b, chr_oe_c;
    logic        chr_we_a, chr_we_b, chr_we_c;
    logic        ciram_ce_a, ciram_ce_b, ciram_ce_c;
    logic        ciram_a10_a, ciram_a10_b, ciram_a10_c;
    logic        bank_write_a, bank_write_b, bank_write_c;

    int tests;
    int failed;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] mdl_a, mdl_b, mdl_c;

    // a: default UNROM, bus conflicts on
    uxrom_ext #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(0), .FIXED_LOW(1'b0),
                .BUS_CONFLICT(1'b1), .ONE_SCREEN_CTRL(1'b0), .ADDR_BITS(22)) dut_a (
        .clk(clk), .reset(reset), .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_in(cpu_data_in), .prg_data(prg_data), .ppu_addr(ppu_addr),
        .ppu_rd(ppu_rd), .ppu_wr(ppu_wr), .chr_ram(chr_ram), .mirroring(mirroring),
        .prg_addr(prg_addr_a), .prg_oe(prg_oe_a), .chr_addr(chr_addr_a),
        .chr_ce(chr_ce_a), .chr_oe(chr_oe_a), .chr_we(chr_we_a),
        .ciram_ce(ciram_ce_a), .ciram_a10(ciram_a10_a), .bank_write(bank_write_a));

    // b: inverted-fixed, no bus conflicts
    uxrom_ext #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(0), .FIXED_LOW(1'b1),
                .BUS_CONFLICT(1'b0), .ONE_SCREEN_CTRL(1'b0), .ADDR_BITS(22)) dut_b (
        .clk(clk), .reset(reset), .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_in(cpu_data_in), .prg_data(prg_data), .ppu_addr(ppu_addr),
        .ppu_rd(ppu_rd), .ppu_wr(ppu_wr), .chr_ram(chr_ram), .mirroring(mirroring),
        .prg_addr(prg_addr_b), .prg_oe(prg_oe_b), .chr_addr(chr_addr_b),
        .chr_ce(chr_ce_b), .chr_oe(chr_oe_b), .chr_we(chr_we_b),
        .ciram_ce(ciram_ce_b), .ciram_a10(ciram_a10_b), .bank_write(bank_write_b));

    // c: UNROM-512 style, CHR banking and one-screen control
    uxrom_ext #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(2), .FIXED_LOW(1'b0),
                .BUS_CONFLICT(1'b1), .ONE_SCREEN_CTRL(1'b1), .ADDR_BITS(22)) dut_c (
        .clk(clk), .reset(reset), .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_in(cpu_data_in), .prg_data(prg_data), .ppu_addr(ppu_addr),
        .ppu_rd(ppu_rd), .ppu_wr(ppu_wr), .chr_ram(chr_ram), .mirroring(mirroring),
        .prg_addr(prg_addr_c), .prg_oe(prg_oe_c), .chr_addr(chr_addr_c),
        .chr_ce(chr_ce_c), .chr_oe(chr_oe_c), .chr_we(chr_we_c),
        .ciram_ce(ciram_ce_c), .ciram_a10(ciram_a10_c), .bank_write(bank_write_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] exp_prg(input bit fl, input logic [4:0] bank,
                                            input logic [15:0] addr);
        logic [4:0] w;
        if (fl) w = addr[14] ? bank : 5'd0;
        else    w = addr[14] ? 5'h1F : bank;
        return {3'b000, w, addr[13:0]};
    endfunction

    // Scoreboard: each commit pops the expected register values and checks the
    // decode of all three instances in the commit cycle.
    always @(negedge clk) begin
        if (bank_write_a) begin
            tests++;
            if (sb_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected_commit: bank_write=1, required 0");
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                mdl_a = e.a; mdl_b = e.b; mdl_c = e.c;
                tests++;
                if (prg_addr_a !== exp_prg(1'b0, mdl_a[4:0], cpu_addr)) begin
                    failed++;
                    $display("FAIL sb_prg_a: got %h, required %h", prg_addr_a, exp_prg(1'b0, mdl_a[4:0], cpu_addr));
                end
                tests++;
                if (prg_addr_b !== exp_prg(1'b1, mdl_b[4:0], cpu_addr)) begin
                    failed++;
                    $display("FAIL sb_prg_b: got %h, required %h", prg_addr_b, exp_prg(1'b1, mdl_b[4:0], cpu_addr));
                end
                tests++;
                if (chr_addr_c !== {7'b0, mdl_c[6:5], ppu_addr[12:0]} || ciram_a10_c !== mdl_c[7]) begin
                    failed++;
                    $display("FAIL sb_chr_c: got %h/%b, required %h/%b", chr_addr_c, ciram_a10_c,
                             {7'b0, mdl_c[6:5], ppu_addr[12:0]}, mdl_c[7]);
                end
            end
        end
        if (bank_write_b !== bank_write_a || bank_write_c !== bank_write_a) begin
            tests++;
            failed++;
            $display("FAIL sb_pulse_align: a=%b b=%b c=%b", bank_write_a, bank_write_b, bank_write_c);
        end
    end

    // One full M2 cycle carrying a CPU write; checks commit latency.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                            input logic [7:0] prg, input bit expect_commit);
        sb_t e;
        int  seen;
        if (expect_commit) begin
            e.a = data & prg;
            e.b = data;
            e.c = data & prg;
            sb_q.push_back(e);
        end
        @(negedge clk);
        cpu_addr = addr; cpu_rw = 1'b0; cpu_data_in = data; prg_data = prg; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2   = 1'b0;
        seen = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bank_write_a && seen == 0) seen = i;
        end
        tests++;
        if (expect_commit && seen != 3) begin
            failed++;
            $display("FAIL write_latency: bank_write after %0d clks, required 3", seen);
        end else if (!expect_commit && seen != 0) begin
            failed++;
            $display("FAIL write_ignored: bank_write after %0d clks, required none", seen);
        end
        cpu_rw = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mdl_a = 8'h00; mdl_b = 8'h00; mdl_c = 8'h00;
        cpu_addr = 16'h8000; cpu_rw = 1'b1; mirroring = 1'b1;
        ppu_addr = 14'h0400; ppu_rd = 1'b0; ppu_wr = 1'b1; chr_ram = 1'b0;
        #1;
        tests++; if (prg_addr_a !== 22'h00000) begin failed++; $display("FAIL rst_prg_8000: got %h, required 00000", prg_addr_a); end
        tests++; if (prg_oe_a !== 1'b1) begin failed++; $display("FAIL rst_prg_oe: got %b, required 1", prg_oe_a); end
        tests++; if (bank_write_a !== 1'b0) begin failed++; $display("FAIL rst_bank_write: got %b, required 0", bank_write_a); end
        tests++; if (ciram_a10_a !== 1'b1) begin failed++; $display("FAIL rst_ciram_mirror: got %b, required 1", ciram_a10_a); end
        tests++; if (ciram_a10_c !== 1'b0) begin failed++; $display("FAIL rst_ciram_onescreen: got %b, required 0", ciram_a10_c); end
        tests++; if (chr_oe_a !== 1'b1) begin failed++; $display("FAIL rst_chr_oe: got %b, required 1", chr_oe_a); end
        cpu_addr = 16'hC000;
        #1;
        tests++; if (prg_addr_a !== 22'h7C000) begin failed++; $display("FAIL rst_prg_c000: got %h, required 7c000", prg_addr_a); end
        tests++; if (prg_addr_b !== 22'h00000) begin failed++; $display("FAIL rst_prg_c000_fixlow: got %h, required 00000", prg_addr_b); end
        cpu_addr = 16'h6000;
        #1;
        tests++; if (prg_oe_a !== 1'b0) begin failed++; $display("FAIL rst_prg_oe_6000: got %b, required 0", prg_oe_a); end
    endtask

    task automatic test_prg_switch;
        do_write(16'h8000, 8'h03, 8'hFF, 1'b1);
        cpu_addr = 16'h8123;
        #1;
        tests++; if (prg_addr_a !== 22'h0C123) begin failed++; $display("FAIL prg_switch_a: got %h, required 0c123", prg_addr_a); end
        tests++; if (prg_addr_b !== 22'h00123) begin failed++; $display("FAIL prg_switch_b: got %h, required 00123", prg_addr_b); end
    endtask

    task automatic test_bus_conflict;
        do_write(16'h8000, 8'h07, 8'h05, 1'b1);
        cpu_addr = 16'h8000;
        #1;
        tests++; if (prg_addr_a !== 22'h14000) begin failed++; $display("FAIL bus_conflict_a: got %h, required 14000", prg_addr_a); end
        tests++; if (prg_addr_c !== 22'h14000) begin failed++; $display("FAIL bus_conflict_c: got %h, required 14000", prg_addr_c); end
        cpu_addr = 16'hC000;
        #1;
        tests++; if (prg_addr_b !== 22'h1C000) begin failed++; $display("FAIL no_conflict_b: got %h, required 1c000", prg_addr_b); end
    endtask

    task automatic test_fixed_low;
        do_write(16'hC555, 8'h02, 8'hFF, 1'b1);
        cpu_addr = 16'h8000;
        #1;
        tests++; if (prg_addr_b !== 22'h00000) begin failed++; $display("FAIL fixed_low_8000: got %h, required 00000", prg_addr_b); end
        cpu_addr = 16'hC010;
        #1;
        tests++; if (prg_addr_b !== 22'h08010) begin failed++; $display("FAIL fixed_low_c010: got %h, required 08010", prg_addr_b); end
        tests++; if (prg_addr_a !== 22'h7C010) begin failed++; $display("FAIL fixed_high_c010: got %h, required 7c010", prg_addr_a); end
    endtask

    task automatic test_chr_one_screen;
        ppu_addr = 14'h0100; chr_ram = 1'b1; ppu_wr = 1'b0; ppu_rd = 1'b1; mirroring = 1'b0;
        do_write(16'h8000, 8'hE1, 8'hFF, 1'b1);
        #1;
        tests++; if (chr_addr_c !== 22'h06100) begin failed++; $display("FAIL chr_bank_c: got %h, required 06100", chr_addr_c); end
        tests++; if (ciram_a10_c !== 1'b1) begin failed++; $display("FAIL one_screen_c: got %b, required 1", ciram_a10_c); end
        tests++; if (chr_we_c !== 1'b1) begin failed++; $display("FAIL chr_we_c: got %b, required 1", chr_we_c); end
        tests++; if (chr_oe_c !== 1'b0 || chr_ce_c !== 1'b1) begin failed++; $display("FAIL chr_oe_ce_c: got %b%b, required 01", chr_oe_c, chr_ce_c); end
        tests++; if (chr_addr_a !== 22'h00100) begin failed++; $display("FAIL chr_nobank_a: got %h, required 00100", chr_addr_a); end
        tests++; if (ciram_a10_a !== 1'b0) begin failed++; $display("FAIL mirror_h_a: got %b, required 0", ciram_a10_a); end
        ppu_addr = 14'h2900;
        #1;
        tests++; if (ciram_a10_a !== 1'b1) begin failed++; $display("FAIL mirror_h_2900: got %b, required 1", ciram_a10_a); end
        tests++; if (chr_we_c !== 1'b0 || chr_ce_c !== 1'b0 || ciram_ce_a !== 1'b0) begin
            failed++; $display("FAIL nametable_decode: got we=%b ce=%b ciram_ce=%b, required 000", chr_we_c, chr_ce_c, ciram_ce_a);
        end
        mirroring = 1'b1;
        #1;
        tests++; if (ciram_a10_a !== 1'b0 || ciram_a10_c !== 1'b1) begin
            failed++; $display("FAIL mirror_v_2900: got a=%b c=%b, required a=0 c=1", ciram_a10_a, ciram_a10_c);
        end
        ppu_addr = 14'h0100; chr_ram = 1'b0;
        #1;
        tests++; if (chr_we_c !== 1'b0) begin failed++; $display("FAIL chr_rom_no_we: got %b, required 0", chr_we_c); end
        ppu_wr = 1'b1;
    endtask

    task automatic test_no_commit;
        do_write(16'h6000, 8'h1F, 8'hFF, 1'b0);
        cpu_addr = 16'h8000;
        #1;
        tests++; if (prg_addr_a !== 22'h04000) begin failed++; $display("FAIL no_commit_6000: got %h, required 04000", prg_addr_a); end
    endtask

    task automatic test_back_to_back;
        do_write(16'h8000, 8'h04, 8'hFF, 1'b1);
        do_write(16'h8000, 8'h06, 8'hFF, 1'b1);
        cpu_addr = 16'h8000;
        #1;
        tests++; if (prg_addr_a !== 22'h18000) begin failed++; $display("FAIL back_to_back_a: got %h, required 18000", prg_addr_a); end
        tests++; if (sb_q.size() != 0) begin failed++; $display("FAIL back_to_back_drain: %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid_write;
        int seen;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_rw = 1'b0; cpu_data_in = 8'h09; prg_data = 8'hFF; m2 = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        mdl_a = 8'h00; mdl_b = 8'h00; mdl_c = 8'h00;
        repeat (3) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bank_write_a) seen = i;
        end
        tests++; if (seen != 0) begin failed++; $display("FAIL rst_mid_bank_write: pulse at clk %0d, required none", seen); end
        cpu_rw = 1'b1; cpu_addr = 16'h8000;
        #1;
        tests++; if (prg_addr_a !== 22'h00000) begin failed++; $display("FAIL rst_mid_prg: got %h, required 00000", prg_addr_a); end
        tests++; if (ciram_a10_c !== 1'b0) begin failed++; $display("FAIL rst_mid_ciram: got %b, required 0", ciram_a10_c); end
    endtask

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1; m2 = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1;
        cpu_data_in = 8'h00; prg_data = 8'h00; ppu_addr = 14'h0000;
        ppu_rd = 1'b1; ppu_wr = 1'b1; chr_ram = 1'b0; mirroring = 1'b0;
        mdl_a = 8'h00; mdl_b = 8'h00; mdl_c = 8'h00;
        test_reset();
        test_prg_switch();
        test_bus_conflict();
        test_fixed_low();
        test_chr_one_screen();
        test_no_commit();
        test_back_to_back();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
